// File: rtl/berger_pkg.sv
// -----------------------------------------------------------------------------
// berger_pkg
// Shared definitions for the Berger-coded memory scrub controller:
//   - default geometry (DEPTH / DATA_W / MASK_W) and check-bit width
//   - FSM state encodings (legacy-compatible localparam constants)
//   - sweep mode encodings
// -----------------------------------------------------------------------------
package berger_pkg;

  localparam int DEPTH_DEF  = 16;
  localparam int DATA_W_DEF = 8;
  localparam int CHK_W      = 4;
  localparam int MASK_W_DEF = DATA_W_DEF + CHK_W;  // check bits sit at [11:8]

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WRITE   = 3'd1;
  localparam state_t S_RD_ADDR = 3'd2;
  localparam state_t S_RD_CHK  = 3'd3;
  localparam state_t S_DONE    = 3'd4;

  typedef enum logic [1:0] {
    MODE_WR_VERIFY = 2'b00,
    MODE_VERIFY    = 2'b01,
    MODE_WRITE     = 2'b10,
    MODE_RSVD      = 2'b11
  } mode_e;

endpackage

// File: rtl/berger_scrub_counters.sv
// -----------------------------------------------------------------------------
// berger_scrub_counters
// Result accumulation for one scrub sweep: three saturating counters and a
// capture of the first failing address.
//   clk, rst          : clock, asynchronous active-low reset
//   clear             : start of a new sweep, zero everything
//   sample            : one word's read result is valid this cycle
//   mem_err           : Berger error flag for that word
//   miscompare        : read data differs from expected pattern
//   addr              : address of the word being sampled
//   err_count / miscompare_count / silent_count : saturating tallies
//   first_err_addr / first_err_valid            : first failing word
// -----------------------------------------------------------------------------
module berger_scrub_counters
  import berger_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample,
  input  logic              mem_err,
  input  logic              miscompare,
  input  logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  miscompare_count,
  output logic [CNT_W-1:0]  silent_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  mis_q, mis_d;
  logic [CNT_W-1:0]  sil_q, sil_d;
  logic [ADDR_W-1:0] first_addr_q, first_addr_d;
  logic              first_valid_q, first_valid_d;

  always_comb begin
    err_d         = err_q;
    mis_d         = mis_q;
    sil_d         = sil_q;
    first_addr_d  = first_addr_q;
    first_valid_d = first_valid_q;
    if (clear) begin
      err_d         = '0;
      mis_d         = '0;
      sil_d         = '0;
      first_addr_d  = '0;
      first_valid_d = 1'b0;
    end else if (sample) begin
      if (mem_err && err_q != CNT_MAX)                 err_d = err_q + CNT_W'(1);
      if (miscompare && mis_q != CNT_MAX)              mis_d = mis_q + CNT_W'(1);
      // A miscompare the Berger code failed to flag is the dangerous case.
      if (miscompare && !mem_err && sil_q != CNT_MAX)  sil_d = sil_q + CNT_W'(1);
      if ((mem_err || miscompare) && !first_valid_q) begin
        first_addr_d  = addr;
        first_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q         <= '0;
      mis_q         <= '0;
      sil_q         <= '0;
      first_addr_q  <= '0;
      first_valid_q <= 1'b0;
    end else begin
      err_q         <= err_d;
      mis_q         <= mis_d;
      sil_q         <= sil_d;
      first_addr_q  <= first_addr_d;
      first_valid_q <= first_valid_d;
    end
  end

  assign err_count        = err_q;
  assign miscompare_count = mis_q;
  assign silent_count     = sil_q;
  assign first_err_addr   = first_addr_q;
  assign first_err_valid  = first_valid_q;

endmodule

// File: rtl/berger_scrub_ctrl.sv
// -----------------------------------------------------------------------------
// berger_scrub_ctrl
// Sweeps a Berger-coded memory: writes the pattern seed+addr, reads it back,
// and tallies Berger errors, data miscompares and silent (undetected) errors.
//   clk, rst            : clock, asynchronous active-low reset
//   start, mode, seed   : sweep request (sampled in IDLE), mode, pattern base
//   inj_addr, inj_mask  : fault-injection target and mask
//   busy, done          : status (done is a one-cycle pulse)
//   mem_*               : memory-side address/write/fault/read interface
//   err_count, miscompare_count, silent_count, first_err_addr/_valid : results
// Optional feature macro: BERGER_SCRUB_FAULT_INJ_EN enables driving
// mem_fault_enable/mem_fault_mask while reading the latched inj_addr.
// -----------------------------------------------------------------------------
module berger_scrub_ctrl
  import berger_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MASK_W = MASK_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [DATA_W-1:0]            seed,
  input  logic [ADDR_W-1:0]            inj_addr,
  input  logic [MASK_W-1:0]            inj_mask,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_wr_en,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [MASK_W-1:0]            mem_fault_mask,
  output logic                         mem_fault_enable,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_err,
  output logic [$clog2(DEPTH+1)-1:0]   err_count,
  output logic [$clog2(DEPTH+1)-1:0]   miscompare_count,
  output logic [$clog2(DEPTH+1)-1:0]   silent_count,
  output logic [ADDR_W-1:0]            first_err_addr,
  output logic                         first_err_valid
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] seed_q,  seed_d;
  mode_e             mode_q,  mode_d;
  logic              accept;
  logic [DATA_W-1:0] expected;

  assign accept   = (state_q == S_IDLE) && start;
  assign expected = seed_q + DATA_W'(addr_q);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d = seed;
          mode_d = mode_e'(mode);
          addr_d = '0;
          case (mode_e'(mode))
            MODE_WR_VERIFY, MODE_WRITE: state_d = S_WRITE;
            MODE_VERIFY:                state_d = S_RD_ADDR;
            default:                    state_d = S_DONE;
          endcase
        end
      end
      S_WRITE: begin
        // The address returns to 0 only on state exit, never by overflow.
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = (mode_q == MODE_WR_VERIFY) ? S_RD_ADDR : S_DONE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_RD_ADDR: state_d = S_RD_CHK;
      S_RD_CHK: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_RD_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all control state has an asynchronous reset so the memory-side
  // outputs, which decode straight from these flops, drop the instant rst
  // falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      mode_q  <= MODE_WR_VERIFY;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
      mode_q  <= mode_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_addr  = addr_q;
  assign mem_wr_en = (state_q == S_WRITE);
  assign mem_wdata = (state_q == S_WRITE) ? expected : '0;

`ifdef BERGER_SCRUB_FAULT_INJ_EN
  logic [ADDR_W-1:0] inj_addr_q;
  logic [MASK_W-1:0] inj_mask_q;
  logic              inj_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inj_addr_q <= '0;
      inj_mask_q <= '0;
    end else if (accept) begin
      inj_addr_q <= inj_addr;
      inj_mask_q <= inj_mask;
    end
  end

  assign inj_hit          = ((state_q == S_RD_ADDR) || (state_q == S_RD_CHK)) &&
                            (addr_q == inj_addr_q);
  assign mem_fault_enable = inj_hit;
  assign mem_fault_mask   = inj_hit ? inj_mask_q : '0;
`else
  logic unused_inj;
  assign unused_inj       = ^{inj_addr, inj_mask};
  assign mem_fault_enable = 1'b0;
  assign mem_fault_mask   = '0;
`endif

  berger_scrub_counters #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_counters (
    .clk              (clk),
    .rst              (rst),
    .clear            (accept),
    .sample           (state_q == S_RD_CHK),
    .mem_err          (mem_err),
    .miscompare       (mem_rdata != expected),
    .addr             (addr_q),
    .err_count        (err_count),
    .miscompare_count (miscompare_count),
    .silent_count     (silent_count),
    .first_err_addr   (first_err_addr),
    .first_err_valid  (first_err_valid)
  );

endmodule

// File: doc/berger_scrub_ctrl.md
BERGER_SCRUB_CTRL -- requirements
Module: berger_scrub_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of memory words swept.
REQ-002 SHALL have parameter ADDR_W, default 4: address width, equal to clog2(DEPTH).
REQ-003 SHALL have parameter DATA_W, default 8: data word width.
REQ-004 SHALL have parameter MASK_W, default 12: codeword width (DATA_W data bits plus 4 Berger check bits at [11:8]).
REQ-005 SHALL have clk, input, 1: single clock, rising edge.
REQ-006 SHALL have rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have start, input, 1: sweep request, sampled in IDLE only.
REQ-008 SHALL have mode, input, 2: 00 write+verify, 01 verify-only, 10 write-only, 11 reserved.
REQ-009 SHALL have seed, input, DATA_W: base of the test pattern.
REQ-010 SHALL have inj_addr, input, ADDR_W: address that receives the injected fault.
REQ-011 SHALL have inj_mask, input, MASK_W: fault mask applied to that address.
REQ-012 SHALL have busy, output, 1: high in every non-IDLE state.
REQ-013 SHALL have done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have mem_addr, output, ADDR_W: memory address.
REQ-015 SHALL have mem_wr_en, output, 1: memory write enable.
REQ-016 SHALL have mem_wdata, output, DATA_W: memory write data.
REQ-017 SHALL have mem_fault_mask, output, MASK_W: fault mask driven to the memory.
REQ-018 SHALL have mem_fault_enable, output, 1: fault enable driven to the memory.
REQ-019 SHALL have mem_rdata, input, DATA_W: memory read data.
REQ-020 SHALL have mem_err, input, 1: Berger error flag from the memory.
REQ-021 SHALL have err_count, output, clog2(DEPTH+1): number of words where mem_err was sampled high.
REQ-022 SHALL have miscompare_count, output, clog2(DEPTH+1): number of words where read data differed from expected.
REQ-023 SHALL have silent_count, output, clog2(DEPTH+1): number of miscompares with mem_err low.
REQ-024 SHALL have first_err_addr, output, ADDR_W: address of the first word with mem_err or a miscompare.
REQ-025 SHALL have first_err_valid, output, 1: first_err_addr holds a valid address.

Function
REQ-026 SHALL implement FSM states IDLE, WRITE, RD_ADDR, RD_CHK and DONE.
REQ-027 SHALL, on start=1 in IDLE, clear all counters and first_err_valid, latch seed/inj_addr/inj_mask/mode, and go to WRITE (mode 00/10), RD_ADDR (mode 01) or DONE (mode 11).
REQ-028 SHALL, in WRITE, drive mem_wr_en=1 with mem_wdata=(seed+addr) mod 2^DATA_W for addr 0..DEPTH-1, one word per cycle.
REQ-029 SHALL, after WRITE, go to RD_ADDR (mode 00) or DONE (mode 10).
REQ-030 SHALL, in RD_ADDR, present the address; in RD_CHK, hold the address and sample mem_rdata/mem_err: 2 cycles per word.
REQ-031 SHALL, in RD_CHK, increment err_count on mem_err, miscompare_count on mem_rdata != seed+addr, and silent_count on a miscompare with mem_err low.
REQ-032 SHALL capture first_err_addr only on the first qualifying word of a sweep.
REQ-033 SHALL, after RD_CHK of address DEPTH-1, go to DONE, then to IDLE after one cycle.
REQ-034 SHALL hold done=1 in DONE only.
REQ-035 SHALL hold results until the next accepted start.
REQ-036 SHALL take 2+3*DEPTH cycles for a mode 00 sweep, start edge to done inclusive (50 for DEPTH 16).
REQ-037 SHALL ignore start while busy.
REQ-038 SHALL keep mem_wr_en=0 outside WRITE.
REQ-039 SHALL wrap the address counter to 0 only via state exit, never by overflow.

Reset
REQ-040 SHALL, on rst low at any time including mid-sweep, immediately force IDLE, busy=0, done=0, mem_wr_en=0, mem_fault_enable=0, mem_addr=0, mem_wdata=0, mem_fault_mask=0, all counters 0, first_err_addr=0 and first_err_valid=0.

Configuration
REQ-041 SHALL, with BERGER_SCRUB_FAULT_INJ_EN defined, drive mem_fault_enable=1 and mem_fault_mask=latched inj_mask during RD_ADDR/RD_CHK of latched inj_addr, and 0 otherwise.
REQ-042 SHALL, without BERGER_SCRUB_FAULT_INJ_EN, tie mem_fault_enable and mem_fault_mask to 0 and leave inj_* ports unused.

Structure
REQ-043 SHALL place the state enum, mode encodings and DATA_W/MASK_W/DEPTH defaults in shared package berger_pkg.
REQ-044 SHALL contain one sub-module, berger_scrub_counters (the three saturating counters plus first-error capture); the FSM stays in the top.

Verification
REQ-045 SHALL cover: seed 0x00, mode 00, no injection -> all counts 0, first_err_valid 0, done 50 cycles after start.
REQ-046 SHALL cover: macro on, seed 0xA5, inj_addr 3, inj_mask 12'h008 -> read 0xA0 at addr 3, err_count 1, miscompare_count 1, silent_count 0, first_err_addr 3.
REQ-047 SHALL cover: macro on, inj_addr 3, inj_mask 12'hF00 -> err_count 1, miscompare_count 0, first_err_addr 3.
REQ-048 SHALL cover: write seed 0x10 (mode 10), then verify seed 0x20 (mode 01) -> miscompare_count 16, silent_count 16, err_count 0.
REQ-049 SHALL cover: start pulsed mid-sweep -> ignored; rst low during WRITE at addr 5 -> mem_wr_en 0 that instant, IDLE, counters 0.
REQ-050 SHALL cover: mode 11 -> done one cycle after start, no memory access, counters 0.
